run_monitor: RTL

Run-control and statistics stage for the single-cycle MIPS core, sitting between the board inputs and the core.
- Debounces the `go` button and drives the core's PC enable.
- Halts the core on a non-display syscall and supports single-step mode.
- Latches display-syscall values and counts committed instructions, jumps and taken branches.
- Presents one of these values to the seven-segment display driver.

---
 rtl/run_monitor_pkg.sv | 18 +
 rtl/button_debounce.sv | 45 ++++
 rtl/run_monitor.sv | 110 +++++++++++
 3 files changed

// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run-control/statistics stage of the MIPS core.
package run_monitor_pkg;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StPause = 2'd1,
      StHalt  = 2'd2
   } run_state_e;

   localparam logic [1:0] SEL_SHOW  = 2'b00;
   localparam logic [1:0] SEL_INSTR = 2'b01;
   localparam logic [1:0] SEL_JMP   = 2'b10;
   localparam logic [1:0] SEL_BR    = 2'b11;

   // $v0 value that marks a syscall as a display request; compared upstream.
   localparam logic [31:0] SYSCALL_SHOW_CODE = 32'h22;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw push-button, debounces it and emits a one-cycle pulse on each
// debounced press.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic            r_sync1;
   logic            r_sync2;
   logic            r_db;
   logic            r_db_q;
   logic [CntW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_db_q  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_db_q  <= r_db;
         // Counter tracks how long the synchronized level has disagreed with r_db.
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CntW'(1);
         end
      end
   end

   assign o_pulse = r_db & ~r_db_q;

endmodule

// File: rtl/run_monitor.sv
// Run control (RUN/PAUSE/HALT) for the single-cycle core, plus commit statistics and
// the display source mux.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             clk,
   input  logic             CPU_RESETN,
   input  logic             go,
   input  logic             step_mode,
   input  logic             syscall,
   input  logic             show,
   input  logic [31:0]      a0,
   input  logic             jmp,
   input  logic             branch,
   input  logic [1:0]       select,
   output logic             pc_enable,
   output logic             halted,
   output logic [CNT_W-1:0] leddata_out
);

   logic             w_go_pulse;
   logic             w_stop;
   run_state_e       r_state;
   run_state_e       w_state_d;
   logic [CNT_W-1:0] r_instr_cnt;
   logic [CNT_W-1:0] r_jmp_cnt;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_show;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_go_debounce (
      .i_clk  (clk),
      .i_rst_n(CPU_RESETN),
      .i_btn  (go),
      .o_pulse(w_go_pulse)
   );

   assign w_stop = syscall & ~show;

   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state <= StRun;
      end else begin
         r_state <= w_state_d;
      end
   end

   // pc_enable is combinational so a halting syscall never commits on entry to HALT.
   always_comb begin
      w_state_d = r_state;
      pc_enable = 1'b0;
      unique case (r_state)
         StRun: begin
            pc_enable = ~w_stop;
            if (w_stop) begin
               w_state_d = StHalt;
            end else if (step_mode) begin
               w_state_d = StPause;
            end
         end
         StPause: begin
            pc_enable = w_go_pulse & ~w_stop;
            if (w_go_pulse & w_stop) begin
               w_state_d = StHalt;
            end else if (w_go_pulse & ~step_mode) begin
               w_state_d = StRun;
            end
         end
         StHalt: begin
            pc_enable = w_go_pulse;
            if (w_go_pulse) begin
               w_state_d = step_mode ? StPause : StRun;
            end
         end
         default: w_state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_instr_cnt <= '0;
         r_jmp_cnt   <= '0;
         r_br_cnt    <= '0;
         r_show      <= '0;
      end else if (pc_enable) begin
         if (r_instr_cnt != '1) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
         if (jmp && (r_jmp_cnt != '1)) r_jmp_cnt <= r_jmp_cnt + CNT_W'(1);
         if (branch && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + CNT_W'(1);
         if (syscall && show) r_show <= CNT_W'(a0);
      end
   end

   always_comb begin
      leddata_out = '0;
      unique case (select)
         SEL_SHOW:  leddata_out = r_show;
         SEL_INSTR: leddata_out = r_instr_cnt;
         SEL_JMP:   leddata_out = r_jmp_cnt;
         SEL_BR:    leddata_out = r_br_cnt;
         default:   leddata_out = '0;
      endcase
   end

   assign halted = (r_state == StHalt);

endmodule
